tx_frame_s: RTL and testbench

- Slave-side transmitter for the 485 acquisition bus; the far end of the master's fetch path.
- On each sync pulse, serializes one fixed-length frame of buffered sample bytes onto the differential line, then releases the bus.
- Sits between the slave sync decoder (source of fire_sync) and the 485 driver pins.
- Contains a small internal byte FIFO filled by the slave data path.

---
 rtl/tx_frame_s_pkg.sv | 32 +++
 rtl/tx_frame_s_fifo.sv | 67 ++++++
 rtl/tx_frame_s.sv | 213 +++++++++++++++++++++
 tb/tb_tx_frame_s.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_s_pkg.sv
// Shared constants, state encoding and character builder for the tx_frame_s slave transmitter.
// Optional macro TX_PARITY_EN widens each character with an even-parity bit.
package tx_frame_s_pkg;

  localparam logic [7:0] SYNC_HDR = 8'hA5;

`ifdef TX_PARITY_EN
  localparam int BITS_PER_CHAR = 11;
`else
  localparam int BITS_PER_CHAR = 10;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GUARD = 3'd2,
    SEND  = 3'd3,
    TAIL  = 3'd4
  } state_t;

  typedef logic [BITS_PER_CHAR-1:0] char_t;

  // Bit 0 goes on the line first: start, data LSB first, [parity], stop.
  function automatic char_t make_char(input logic [7:0] b);
`ifdef TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/tx_frame_s_fifo.sv
// Single-clock show-ahead byte FIFO feeding the frame serializer.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module tx_fifo_s #(
  parameter int AW = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic [AW:0]   w_count_nxt;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/tx_frame_s.sv
// Slave 485 frame transmitter: on fire_sync waits its slot, then sends A5, DEV_ID, payload, checksum.
// Optional macro TX_PARITY_EN adds an even-parity bit to every character.
module tx_frame_s
  import tx_frame_s_pkg::*;
#(
  parameter int         CLK_DIV  = 100,
  parameter int         NUM_BYTE = 8,
  parameter int         SLOT_DLY = 1000,
  parameter logic [7:0] DEV_ID   = 8'h01,
  parameter int         FIFO_AW  = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       fire_sync,
  input  logic [7:0] data_in,
  input  logic       data_vld,
  output logic       data_full,
  output logic       tx_ctrl,
  output logic       tx_a,
  output logic       tx_b,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow,
  output logic       sync_miss,
  output state_t     o_dbg_state
);

  localparam int NUM_CHAR = NUM_BYTE + 3;
  localparam int CNT_MAX  = (SLOT_DLY > 2*CLK_DIV) ? SLOT_DLY : 2*CLK_DIV;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int XW       = $clog2(NUM_CHAR + 1);
  localparam int BW       = $clog2(BITS_PER_CHAR + 1);

  localparam logic [CW-1:0] SLOT_LAST     = CW'(SLOT_DLY - 1);
  localparam logic [CW-1:0] GUARD_LAST    = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST      = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [BW-1:0] CHAR_BIT_LAST = BW'(BITS_PER_CHAR - 1);
  localparam logic [BW-1:0] BIT_ONE       = BW'(1);
  localparam logic [XW-1:0] CHAR_LAST     = XW'(NUM_CHAR - 1);
  localparam logic [XW-1:0] PAY_FIRST     = XW'(2);
  localparam logic [XW-1:0] PAY_LAST      = XW'(NUM_BYTE + 1);
  localparam logic [XW-1:0] IDX_ONE       = XW'(1);

  // Data input handshake: data_vld is a one-cycle write strobe; data_full is the
  // ready-low indication, and a strobe while full is dropped unless a pop frees a slot.

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [XW-1:0] r_char;
  char_t         r_shift;
  logic [7:0]    r_sum;
  logic          r_tx_ctrl;
  logic          r_tx_a;
  logic          r_tx_b;
  logic          r_busy;
  logic          r_done;
  logic          r_uf;
  logic          r_miss;

  logic          w_load;
  logic [XW-1:0] w_ld_idx;
  logic          w_ld_pay;
  logic          w_pop;
  logic [7:0]    w_fifo_rd;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_pay_byte;
  logic [7:0]    w_char_byte;
  char_t         w_char;

  tx_fifo_s #(.AW(FIFO_AW)) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .i_push  (data_vld),
    .i_wdata (data_in),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A character is loaded at the end of the guard time and at the end of every stop bit but the last.
  assign w_load = ((r_state == GUARD) && (r_cnt == GUARD_LAST)) ||
                  ((r_state == SEND) && (r_cnt == BIT_LAST) &&
                   (r_bit == CHAR_BIT_LAST) && (r_char != CHAR_LAST));
  assign w_ld_idx   = (r_state == GUARD) ? '0 : (r_char + IDX_ONE);
  assign w_ld_pay   = w_load && (w_ld_idx >= PAY_FIRST) && (w_ld_idx <= PAY_LAST);
  assign w_pop      = w_ld_pay && !w_fifo_empty;
  assign w_pay_byte = w_fifo_empty ? 8'h00 : w_fifo_rd;

  always_comb begin
    w_char_byte = w_pay_byte;
    if (w_ld_idx == '0) begin
      w_char_byte = SYNC_HDR;
    end else if (w_ld_idx == IDX_ONE) begin
      w_char_byte = DEV_ID;
    end else if (w_ld_idx == CHAR_LAST) begin
      w_char_byte = r_sum;
    end
  end

  assign w_char = make_char(w_char_byte);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_char    <= '0;
      r_shift   <= '1;
      r_sum     <= '0;
      r_tx_ctrl <= 1'b0;
      r_tx_a    <= 1'b1;
      r_tx_b    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_uf      <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_uf   <= 1'b0;
      r_miss <= fire_sync && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (fire_sync) begin
            r_state <= WAIT;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_sum   <= DEV_ID;
          end
        end
        WAIT: begin
          if (r_cnt == SLOT_LAST) begin
            r_state   <= GUARD;
            r_tx_ctrl <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_char  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        SEND: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (r_bit == CHAR_BIT_LAST) begin
              r_bit <= '0;
              if (r_char == CHAR_LAST) begin
                r_state <= TAIL;
              end else begin
                r_char <= r_char + IDX_ONE;
              end
            end else begin
              r_bit   <= r_bit + BIT_ONE;
              r_tx_a  <= r_shift[0];
              r_tx_b  <= ~r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        TAIL: begin
          if (r_cnt == BIT_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tx_ctrl <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_tx_ctrl <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
      // Start bit goes out immediately; the remaining bits wait in the shifter.
      if (w_load) begin
        r_tx_a  <= 1'b0;
        r_tx_b  <= 1'b1;
        r_shift <= w_char >> 1;
        if (w_ld_pay) begin
          r_sum <= r_sum + w_pay_byte;
          r_uf  <= w_fifo_empty;
        end
      end
    end
  end

  assign data_full   = w_fifo_full;
  assign tx_ctrl     = r_tx_ctrl;
  assign tx_a        = r_tx_a;
  assign tx_b        = r_tx_b;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign underflow   = r_uf;
  assign sync_miss   = r_miss;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tx_frame_s.sv
// Directed bench for tx_frame_s: line decoder monitor plus expected-byte scoreboard.
// Follows TX_PARITY_EN to decode 10- or 11-bit characters.
module tb_tx_frame_s;

  localparam int         CLK_DIV  = 4;
  localparam int         NUM_BYTE = 4;
  localparam int         SLOT_DLY = 10;
  localparam int         FIFO_AW  = 2;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] DEV_ID   = 8'h01;
`ifdef TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       fire_sync;
  logic [7:0] data_in;
  logic       data_vld;
  logic       data_full;
  logic       tx_ctrl;
  logic       tx_a;
  logic       tx_b;
  logic       busy;
  logic       frame_done;
  logic       underflow;
  logic       sync_miss;
  logic [2:0] dbg_state;

  tx_frame_s #(
    .CLK_DIV  (CLK_DIV),
    .NUM_BYTE (NUM_BYTE),
    .SLOT_DLY (SLOT_DLY),
    .DEV_ID   (DEV_ID),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .fire_sync   (fire_sync),
    .data_in     (data_in),
    .data_vld    (data_vld),
    .data_full   (data_full),
    .tx_ctrl     (tx_ctrl),
    .tx_a        (tx_a),
    .tx_b        (tx_b),
    .busy        (busy),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .sync_miss   (sync_miss),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int         n_assert = 0;
  int         n_fail = 0;
  int         frames_seen = 0;
  int         uf_seen = 0;
  int         miss_seen = 0;
  int         fire_cyc = 0;
  int         exp_uf = 0;
  bit         first_char = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic push_byte(input logic [7:0] b);
    data_in  = b;
    data_vld = 1'b1;
    if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
    @(negedge clk_sys);
    data_vld = 1'b0;
    chk("data_full", data_full, (mdl_q.size() == DEPTH));
  endtask

  task automatic fire_frame();
    logic [7:0] b;
    logic [7:0] sum;
    exp_uf = 0;
    sum = DEV_ID;
    exp_q.push_back(8'hA5);
    exp_q.push_back(DEV_ID);
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (mdl_q.size() > 0) begin
        b = mdl_q.pop_front();
      end else begin
        b = 8'h00;
        exp_uf++;
      end
      sum = sum + b;
      exp_q.push_back(b);
    end
    exp_q.push_back(sum);
    first_char = 1'b1;
    fire_cyc   = cyc;
    fire_sync  = 1'b1;
    @(negedge clk_sys);
    fire_sync = 1'b0;
    chk("busy_after_fire", busy, 1);
  endtask

  task automatic wait_done(input int f0);
    int n;
    n = 0;
    while (frames_seen == f0 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("frame_timeout", (frames_seen == f0), 0);
    @(negedge clk_sys);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("tx_ctrl_idle", tx_ctrl, 0);
  endtask

  // Monitor: line checks and serial decode into the scoreboard
  logic       rx_active = 1'b0;
  logic       prev_ctrl = 1'b0;
  logic       rx_par;
  logic [7:0] rx_byte;
  logic [7:0] e;
  int         rx_t0 = 0;
  int         last_t0 = 0;
  int         off;
  int         j;

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      rx_active = 1'b0;
      prev_ctrl = 1'b0;
    end else begin
      if (tx_ctrl) begin
        chk("line_diff", {31'b0, tx_b}, {31'b0, ~tx_a});
      end else begin
        chk("idle_a", tx_a, 1);
        chk("idle_b", tx_b, 0);
      end
      if (tx_ctrl && !prev_ctrl) chk("ctrl_rise_cyc", cyc - fire_cyc, SLOT_DLY + 1);
      prev_ctrl = tx_ctrl;
      if (underflow) uf_seen++;
      if (sync_miss) miss_seen++;
      if (!rx_active) begin
        if (tx_ctrl && tx_a == 1'b0) begin
          rx_active = 1'b1;
          rx_t0     = cyc;
          rx_byte   = 8'h00;
          if (first_char) begin
            chk("start_cyc", cyc - fire_cyc, SLOT_DLY + 1 + 2*CLK_DIV);
            first_char = 1'b0;
          end
        end
      end else begin
        off = cyc - rx_t0;
        if (off % CLK_DIV == CLK_DIV/2) begin
          j = off / CLK_DIV;
          if (j == BITS - 1) begin
            chk("stop_bit", tx_a, 1);
`ifdef TX_PARITY_EN
            chk("parity_bit", rx_par, ^rx_byte);
`endif
            chk("rx_q_empty", (exp_q.size() == 0), 0);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("rx_byte", rx_byte, e);
            end
            last_t0   = rx_t0;
            rx_active = 1'b0;
          end else if (j >= 1 && j <= 8) begin
            rx_byte[j-1] = tx_a;
          end else if (j == 9) begin
            rx_par = tx_a;
          end
        end
      end
      if (frame_done) begin
        chk("done_cyc", cyc - last_t0, CLK_DIV*BITS + CLK_DIV);
        chk("busy_at_done", busy, 0);
        frames_seen++;
      end
    end
  end

  // Directed sequence
  int f0;
  int uf0;
  int m0;

  initial begin
    rst_n     = 1'b0;
    fire_sync = 1'b0;
    data_vld  = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk("rst_tx_ctrl", tx_ctrl, 0);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_tx_b", tx_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_sync_miss", sync_miss, 0);
    chk("rst_data_full", data_full, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Fill past capacity: fifth byte is dropped, frame carries the first four.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    uf0 = uf_seen;
    f0  = frames_seen;
    fire_frame();
    wait_done(f0);
    chk("uf_full_frame", uf_seen - uf0, exp_uf);
    chk("full_cleared", data_full, 0);

    // Short by one byte: one pad, one underflow pulse.
    for (int i = 0; i < NUM_BYTE - 1; i++) push_byte(8'($urandom_range(1, 255)));
    uf0 = uf_seen;
    f0  = frames_seen;
    fire_frame();
    wait_done(f0);
    chk("uf_count", uf_seen - uf0, exp_uf);
    chk("uf_one", exp_uf, 1);

    // Second fire_sync during SEND.
    for (int i = 0; i < NUM_BYTE; i++) push_byte(8'($urandom_range(0, 255)));
    m0 = miss_seen;
    f0 = frames_seen;
    fire_frame();
    repeat (SLOT_DLY + 2*CLK_DIV + 2*CLK_DIV*BITS) @(negedge clk_sys);
    chk("state_send", dbg_state, 3);
    fire_sync = 1'b1;
    @(negedge clk_sys);
    fire_sync = 1'b0;
    wait_done(f0);
    chk("sync_miss_count", miss_seen - m0, 1);
    repeat (40) @(negedge clk_sys);
    chk("no_second_frame", frames_seen - f0, 1);
    chk("no_second_ctrl", tx_ctrl, 0);
    chk("no_second_busy", busy, 0);

    // Reset in the middle of SEND, then a clean frame.
    for (int i = 0; i < NUM_BYTE; i++) push_byte(8'($urandom_range(0, 255)));
    f0 = frames_seen;
    fire_frame();
    repeat (SLOT_DLY + 2*CLK_DIV + 2*CLK_DIV*BITS) @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx_ctrl", tx_ctrl, 0);
    chk("mrst_tx_a", tx_a, 1);
    chk("mrst_tx_b", tx_b, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data_full", data_full, 0);
    exp_q.delete();
    mdl_q.delete();
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_sys);
    chk("no_done_after_reset", frames_seen - f0, 0);
    push_byte(8'h07);
    push_byte(8'hF0);
    push_byte(8'h80);
    push_byte(8'h01);
    uf0 = uf_seen;
    f0  = frames_seen;
    fire_frame();
    wait_done(f0);
    chk("post_reset_frame", frames_seen - f0, 1);
    chk("post_reset_uf", uf_seen - uf0, exp_uf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
